uart_mmio_bridge: RTL and testbench

//  Memory-mapped register front end between the CPU data bus and the UART core. Decodes a
//  4-byte window at BASE_ADDR and buffers traffic in parametrised TX/RX FIFOs. Drives the

---
 rtl/uart_mmio_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_mmio_bridge.sv | 139 +++++++++++++
 tb/tb_uart_mmio_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, bit indices and TX FSM states for the UART MMIO bridge
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_ACTIVE  = 5;
  localparam int ST_TX_DROP    = 6;

  localparam int CT_TX_EN  = 0;
  localparam int CT_RX_EN  = 1;
  localparam int CT_IRQ_EN = 2;

  localparam logic [2:0] CTRL_RESET = 3'b011;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_LAUNCH    = 2'd1;
  localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
  localparam logic [1:0] TX_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-bit pointers, exposes head/full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - CPU bus register window over TX/RX FIFOs and the UART begin/busy handshake
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hFC,
  parameter int                TX_DEPTH  = 4,
  parameter int                RX_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_w_data,
  input  logic              bus_w_en,
  input  logic              bus_r_en,
  output logic [DATA_W-1:0] bus_r_data,
  output logic              bus_hit,
  output logic              uart_tx_en,
  output logic              uart_rx_en,
  output logic              uart_begin,
  output logic [DATA_W-1:0] uart_tx_data,
  input  logic              uart_busy,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_receive,
  output logic              irq
);

  logic [ADDR_W-1:0] offset;
  logic [1:0]        reg_sel;
  logic              wr_hit;
  logic              status_wr;
  logic [2:0]        ctrl;
  logic              tx_drop;
  logic              rx_overrun;
  logic              recv_q;
  logic [1:0]        tx_state;
  logic [1:0]        tx_state_next;
  logic              tx_launch;
  logic              tx_push_req;
  logic              tx_full, tx_empty;
  logic              rx_full, rx_empty;
  logic              rx_pop, rx_push_req;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [6:0]        status_bits;

  // Subtracting the base handles a window that is not 4-byte aligned
  assign offset  = bus_addr - BASE_ADDR;
  assign bus_hit = (offset[ADDR_W-1:2] == '0);
  assign reg_sel = offset[1:0];

  assign wr_hit      = bus_w_en & bus_hit;
  assign status_wr   = wr_hit & (reg_sel == OFF_STATUS);
  assign tx_push_req = wr_hit & (reg_sel == OFF_TXDATA);
  assign rx_pop      = bus_r_en & bus_hit & (reg_sel == OFF_RXDATA) & ~rx_empty;
  assign rx_push_req = uart_receive & ~recv_q & ctrl[CT_RX_EN];

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (tx_push_req & ~tx_full),
    .pop     (tx_launch),
    .din     (bus_w_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .head    (tx_head)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push_req),
    .pop     (rx_pop),
    .din     (uart_rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .head    (rx_head)
  );

  assign status_bits = {tx_drop, (tx_state != TX_IDLE), rx_overrun, rx_full,
                        ~rx_empty, tx_empty, tx_full};

  always_comb begin
    bus_r_data = '0;
    if (bus_hit) begin
      case (reg_sel)
        OFF_RXDATA: bus_r_data = rx_empty ? '0 : rx_head;
        OFF_STATUS: bus_r_data = {{(DATA_W-7){1'b0}}, status_bits};
        OFF_CTRL:   bus_r_data = {{(DATA_W-3){1'b0}}, ctrl};
        default:    bus_r_data = '0;
      endcase
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_launch     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (~tx_empty & ctrl[CT_TX_EN] & ~uart_busy) begin
          tx_launch     = 1'b1;
          tx_state_next = TX_LAUNCH;
        end
      end
      TX_LAUNCH:    tx_state_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (uart_busy)  tx_state_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_busy) tx_state_next = TX_IDLE;
      default:      tx_state_next = TX_IDLE;
    endcase
  end

  assign uart_begin = (tx_state == TX_LAUNCH);
  assign uart_tx_en = ctrl[CT_TX_EN];
  assign uart_rx_en = ctrl[CT_RX_EN];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state     <= TX_IDLE;
      uart_tx_data <= '0;
      ctrl         <= CTRL_RESET;
      tx_drop      <= 1'b0;
      rx_overrun   <= 1'b0;
      recv_q       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      tx_state <= tx_state_next;
      recv_q   <= uart_receive;
      irq      <= ctrl[CT_IRQ_EN] & ~rx_empty;
      if (tx_launch) uart_tx_data <= tx_head;
      if (wr_hit && reg_sel == OFF_CTRL) ctrl <= bus_w_data[2:0];
      // A new event in the same cycle as a W1C keeps the flag set
      tx_drop    <= (tx_push_req & tx_full) |
                    (tx_drop & ~(status_wr & bus_w_data[ST_TX_DROP]));
      rx_overrun <= (rx_push_req & rx_full & ~rx_pop) |
                    (rx_overrun & ~(status_wr & bus_w_data[ST_RX_OVERRUN]));
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - directed self-checking bench for uart_mmio_bridge
module tb_uart_mmio_bridge;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] bus_addr = 8'h00;
  logic [7:0] bus_w_data = 8'h00;
  logic       bus_w_en = 1'b0;
  logic       bus_r_en = 1'b0;
  logic [7:0] bus_r_data;
  logic       bus_hit;
  logic       uart_tx_en, uart_rx_en, uart_begin;
  logic [7:0] uart_tx_data;
  logic       uart_busy = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_receive = 1'b0;
  logic       irq;

  int n_checks = 0;
  int n_pass = 0;
  int begin_cnt = 0;

  uart_mmio_bridge dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus_addr     (bus_addr),
    .bus_w_data   (bus_w_data),
    .bus_w_en     (bus_w_en),
    .bus_r_en     (bus_r_en),
    .bus_r_data   (bus_r_data),
    .bus_hit      (bus_hit),
    .uart_tx_en   (uart_tx_en),
    .uart_rx_en   (uart_rx_en),
    .uart_begin   (uart_begin),
    .uart_tx_data (uart_tx_data),
    .uart_busy    (uart_busy),
    .uart_rx_data (uart_rx_data),
    .uart_receive (uart_receive),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (uart_begin) begin_cnt <= begin_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // All bus tasks start and end on a falling edge
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a; bus_w_data = d; bus_w_en = 1'b1;
    @(negedge clock);
    bus_w_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus_addr = a; bus_r_en = 1'b1;
    #1 check(tag, bus_r_data, exp);
    @(negedge clock);
    bus_r_en = 1'b0;
  endtask

  task automatic peek_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus_addr = a;
    #1 check(tag, bus_r_data, exp);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    uart_rx_data = d; uart_receive = 1'b1;
    @(negedge clock);
    uart_receive = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_begin(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (uart_begin) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic handshake();
    uart_busy = 1'b1;
    repeat (2) @(negedge clock);
    uart_busy = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state and decode
    peek_check("reset_status", 8'hFE, 8'h02);
    peek_check("reset_ctrl", 8'hFF, 8'h03);
    check("reset_irq", irq, 1'b0);
    check("reset_begin", uart_begin, 1'b0);
    check("reset_tx_data", uart_tx_data, 8'h00);
    check("reset_en", {uart_rx_en, uart_tx_en}, 2'b11);
    bus_addr = 8'hFB;
    #1 check("outside_hit", bus_hit, 1'b0);
    bus_addr = 8'hFF;
    #1 check("inside_hit", bus_hit, 1'b1);

    // Single byte launch latency
    bus_write(8'hFC, 8'h41);
    @(negedge clock);
    check("tx1_begin", uart_begin, 1'b1);
    check("tx1_data", uart_tx_data, 8'h41);
    peek_check("tx1_status", 8'hFE, 8'h22);
    @(negedge clock);
    check("tx1_begin_one_cycle", uart_begin, 1'b0);
    handshake();
    @(negedge clock);
    peek_check("tx1_done_status", 8'hFE, 8'h02);

    // TX overflow with busy UART
    b0 = begin_cnt;
    uart_busy = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 5; i++) bus_write(8'hFC, 8'hA0 + 8'(i));
    peek_check("tx_full_status", 8'hFE, 8'h41);
    bus_write(8'hFE, 8'h40);
    peek_check("tx_drop_clear", 8'hFE, 8'h01);
    uart_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_begin("tx_drain_begin");
      check("tx_drain_data", uart_tx_data, 8'hA0 + 8'(i));
      handshake();
    end
    repeat (10) @(negedge clock);
    check("tx_drain_count", begin_cnt - b0, 4);
    peek_check("tx_drain_status", 8'hFE, 8'h02);

    // Writes outside the window are ignored
    bus_write(8'hFB, 8'h5A);
    repeat (3) @(negedge clock);
    peek_check("outside_write", 8'hFE, 8'h02);

    // tx_enable gating
    b0 = begin_cnt;
    bus_write(8'hFF, 8'h02);
    bus_write(8'hFC, 8'h77);
    repeat (4) @(negedge clock);
    check("txen_off_no_begin", begin_cnt - b0, 0);
    peek_check("txen_off_status", 8'hFE, 8'h00);
    bus_write(8'hFF, 8'h03);
    wait_begin("txen_on_begin");
    check("txen_on_data", uart_tx_data, 8'h77);
    handshake();

    // RX overrun
    for (int i = 0; i < 5; i++) rx_pulse(8'h10 + 8'(i));
    peek_check("rx_overrun_status", 8'hFE, 8'h1E);
    check("rx_irq_disabled", irq, 1'b0);
    for (int i = 0; i < 4; i++) read_check("rx_read", 8'hFD, 8'h10 + 8'(i));
    read_check("rx_empty_read", 8'hFD, 8'h00);
    peek_check("rx_after_empty", 8'hFE, 8'h12);
    bus_write(8'hFE, 8'h10);
    peek_check("rx_overrun_clear", 8'hFE, 8'h02);

    // Pop and push in the same cycle while full
    for (int i = 0; i < 4; i++) rx_pulse(8'h20 + 8'(i));
    bus_addr = 8'hFD; bus_r_en = 1'b1;
    uart_rx_data = 8'h55; uart_receive = 1'b1;
    #1 check("rx_simul_head", bus_r_data, 8'h20);
    @(negedge clock);
    bus_r_en = 1'b0; uart_receive = 1'b0;
    @(negedge clock);
    peek_check("rx_simul_status", 8'hFE, 8'h0E);
    read_check("rx_simul_r1", 8'hFD, 8'h21);
    read_check("rx_simul_r2", 8'hFD, 8'h22);
    read_check("rx_simul_r3", 8'hFD, 8'h23);
    read_check("rx_simul_last", 8'hFD, 8'h55);

    // Interrupt
    bus_write(8'hFF, 8'h07);
    @(negedge clock);
    peek_check("irq_ctrl", 8'hFF, 8'h07);
    check("irq_idle", irq, 1'b0);
    rx_pulse(8'h66);
    check("irq_set", irq, 1'b1);
    read_check("irq_outside_read", 8'hF9, 8'h00);
    read_check("irq_read", 8'hFD, 8'h66);
    @(negedge clock);
    check("irq_clear", irq, 1'b0);

    // Reset while waiting for the UART to finish
    rx_pulse(8'h33);
    bus_write(8'hFC, 8'h99);
    wait_begin("rst_begin");
    uart_busy = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_pre_irq", irq, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_begin_low", uart_begin, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_tx_data", uart_tx_data, 8'h00);
    peek_check("rst_status", 8'hFE, 8'h02);
    peek_check("rst_ctrl", 8'hFF, 8'h03);
    @(negedge clock);
    uart_busy = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    read_check("rst_rx_lost", 8'hFD, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
